// File: rtl/ds1302_if.sv
// ds1302_if: time snapshot / time edit bundle between the UI and
// the DS1302 serial controller.
interface ds1302_if;
    logic       write_req;
    logic [7:0] write_second;
    logic [7:0] write_minute;
    logic [7:0] write_hour;
    logic [7:0] write_date;
    logic [7:0] write_month;
    logic [7:0] write_week;
    logic [7:0] write_year;
    logic       busy;
    logic [7:0] read_second;
    logic [7:0] read_minute;
    logic [7:0] read_hour;
    logic [7:0] read_date;
    logic [7:0] read_month;
    logic [7:0] read_week;
    logic [7:0] read_year;
    logic       read_valid;

    modport master (
        output write_req, write_second, write_minute, write_hour,
        output write_date, write_month, write_week, write_year,
        input  busy, read_valid,
        input  read_second, read_minute, read_hour,
        input  read_date, read_month, read_week, read_year
    );

    modport slave (
        input  write_req, write_second, write_minute, write_hour,
        input  write_date, write_month, write_week, write_year,
        output busy, read_valid,
        output read_second, read_minute, read_hour,
        output read_date, read_month, read_week, read_year
    );
endinterface

// File: rtl/ds1302_ctrl.sv
// ds1302_ctrl: 3-wire DS1302 master. Polls the seven time registers
// and commits WP-bracketed time writes.
module ds1302_ctrl #(
    parameter int CLK_DIV     = 50,
    parameter int POLL_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic ds1302_ce,
    output logic ds1302_sclk,
    inout  wire  ds1302_io,
    ds1302_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_GAP  = DW'(CLK_DIV - 2);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, NEXT} state_t;

    state_t        state, state_d;
    logic [DW-1:0] div_cnt;
    logic [4:0]    half_cnt;
    logic [3:0]    tx_idx;
    logic          seq_wr;
    logic [PW-1:0] poll_cnt;
    logic          pending;
    logic [7:0]    wr_in  [7];
    logic [7:0]    wr_lat [7];
    logic [7:0]    wr_act [7];
    logic [7:0]    shadow [7];
    logic [7:0]    rd_q   [7];
    logic          rd_valid_q;
    logic [7:0]    rx;
    logic          half_end, last_tx, wr_go, poll_hit;
    logic          start_wr, start_rd, samp;
    logic [15:0]   word;
    logic [3:0]    wi;
    logic [5:0]    hp1;
    logic [4:0]    bidx;
    logic          io_oe, io_bit;

    assign wr_in[0] = bus.write_second;
    assign wr_in[1] = bus.write_minute;
    assign wr_in[2] = bus.write_hour;
    assign wr_in[3] = bus.write_date;
    assign wr_in[4] = bus.write_month;
    assign wr_in[5] = bus.write_week;
    assign wr_in[6] = bus.write_year;

    assign half_end = (div_cnt == DIV_LAST);
    assign last_tx  = seq_wr ? (tx_idx == 4'd8) : (tx_idx == 4'd6);
    assign wr_go    = pending | bus.write_req;
    assign poll_hit = (poll_cnt == POLL_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state; a finished write chains straight into another write or a read
    always_comb begin
        state_d  = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_go) begin
                    start_wr = 1'b1;
                    state_d  = SETUP;
                end else if (poll_hit) begin
                    start_rd = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: if (half_end) state_d = SHIFT;
            SHIFT: if (half_end && half_cnt == 5'd31) state_d = GAP;
            GAP:   if (half_cnt == 5'd1 && div_cnt == DIV_GAP) state_d = NEXT;
            NEXT: begin
                if (!last_tx) begin
                    state_d = SETUP;
                end else if (seq_wr) begin
                    state_d  = SETUP;
                    start_wr = wr_go;
                    start_rd = !wr_go;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Half-period timing; GAP is one clock short so NEXT completes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (state_d != state) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (half_end) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 5'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sequence type and transaction index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_wr <= 1'b0;
            tx_idx <= '0;
        end else if (start_wr) begin
            seq_wr <= 1'b1;
            tx_idx <= '0;
        end else if (start_rd) begin
            seq_wr <= 1'b0;
            tx_idx <= '0;
        end else if (state == NEXT) begin
            tx_idx <= tx_idx + 4'd1;
        end
    end

    // Idle poll counter, held at zero while a sequence runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               poll_cnt <= '0;
        else if (state != IDLE || state_d != IDLE) poll_cnt <= '0;
        else                                      poll_cnt <= poll_cnt + 1'b1;
    end

    // Write request latch; the active copy is frozen for the running write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                wr_lat[i] <= '0;
                wr_act[i] <= '0;
            end
        end else if (start_wr) begin
            pending <= 1'b0;
            for (int i = 0; i < 7; i++)
                wr_act[i] <= bus.write_req ? wr_in[i] : wr_lat[i];
        end else if (bus.write_req) begin
            pending <= 1'b1;
            for (int i = 0; i < 7; i++) wr_lat[i] <= wr_in[i];
        end
    end

    // Command/data word of the current transaction (cmd in [7:0])
    always_comb begin
        word = '0;
        wi   = tx_idx - 4'd1;
        if (!seq_wr) begin
            word[7:0] = 8'h81 + {3'b000, tx_idx, 1'b0};
        end else if (tx_idx == 4'd0) begin
            word = 16'h008E;
        end else if (tx_idx == 4'd8) begin
            word = 16'h808E;
        end else begin
            word[7:0]  = 8'h80 + {3'b000, wi, 1'b0};
            word[15:8] = wr_act[wi[2:0]];
            if (wi == 4'd0 || wi == 4'd2) word[15] = 1'b0;
        end
    end

    assign hp1    = {1'b0, half_cnt} + 6'd1;
    assign bidx   = hp1[5:1];
    assign io_bit = bidx[4] ? word[15] : word[bidx[3:0]];
    assign io_oe  = (state == SETUP || state == SHIFT) &&
                    (seq_wr || bidx[4:3] == 2'b00);
    assign samp   = (state == SHIFT) && half_end && half_cnt[0] &&
                    !seq_wr && half_cnt >= 5'd15 && half_cnt <= 5'd29;

    assign ds1302_ce   = (state == SETUP) || (state == SHIFT);
    assign ds1302_sclk = (state == SHIFT) && !half_cnt[0];
    assign ds1302_io   = io_oe ? io_bit : 1'bz;

    // Read data capture, LSB first, into the per-register shadows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx <= '0;
            for (int i = 0; i < 7; i++) shadow[i] <= '0;
        end else begin
            if (samp) rx <= {ds1302_io, rx[7:1]};
            if (state == SHIFT && state_d == GAP && !seq_wr)
                shadow[tx_idx[2:0]] <= rx;
        end
    end

    // Coherent snapshot publish with control bits masked off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            for (int i = 0; i < 7; i++) rd_q[i] <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (state == NEXT && last_tx && !seq_wr) begin
                rd_q[0]    <= shadow[0] & 8'h7F;
                rd_q[1]    <= shadow[1];
                rd_q[2]    <= shadow[2] & 8'h3F;
                rd_q[3]    <= shadow[3] & 8'h3F;
                rd_q[4]    <= shadow[4] & 8'h1F;
                rd_q[5]    <= shadow[5] & 8'h07;
                rd_q[6]    <= shadow[6];
                rd_valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state != IDLE) || (state_d != IDLE);
    assign bus.read_valid  = rd_valid_q;
    assign bus.read_second = rd_q[0];
    assign bus.read_minute = rd_q[1];
    assign bus.read_hour   = rd_q[2];
    assign bus.read_date   = rd_q[3];
    assign bus.read_month  = rd_q[4];
    assign bus.read_week   = rd_q[5];
    assign bus.read_year   = rd_q[6];
endmodule

// File: tb/tb_ds1302_ctrl.sv
// tb_ds1302_ctrl: DS1302 pin model plus scoreboards for snapshots
// and committed writes.
module tb_ds1302_ctrl;
    localparam int CLK_DIV = 4;
    localparam int POLL    = 100;

    typedef logic [6:0][7:0] snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ds1302_ce, ds1302_sclk;
    wire  ds1302_io;
    logic m_oe = 1'b0;
    logic m_bit = 1'b0;

    ds1302_if bus();

    ds1302_ctrl #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ds1302_ce(ds1302_ce),
        .ds1302_sclk(ds1302_sclk),
        .ds1302_io(ds1302_io),
        .bus(bus)
    );

    pullup (ds1302_io);
    assign ds1302_io = m_oe ? m_bit : 1'bz;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    snap_t snap_q[$];
    logic [15:0] wr_q[$];

    logic [7:0] regs [8];
    logic       wp = 1'b1;
    logic [7:0] cmd, dat, first_cmd, last_cmd;
    int         m_cnt = 0;
    int         tx_count = 0;
    int         commit_cnt = 0;
    logic       pce = 1'b0;
    logic       psc = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // DS1302 pin-level model
    always @(ds1302_ce or ds1302_sclk) begin
        if (ds1302_ce && !pce) begin
            m_cnt = 0;
            cmd = 8'h00;
            dat = 8'h00;
        end
        if (ds1302_ce && ds1302_sclk && !psc) begin
            if (m_cnt < 8) cmd[m_cnt] = ds1302_io;
            else if (m_cnt < 16 && !cmd[0]) dat[m_cnt-8] = ds1302_io;
            m_cnt++;
        end
        if (ds1302_ce && !ds1302_sclk && psc) begin
            if (cmd[0] && m_cnt >= 8 && m_cnt < 16) begin
                m_oe = 1'b1;
                m_bit = regs[cmd[3:1]][m_cnt-8];
            end else begin
                m_oe = 1'b0;
            end
        end
        if (!ds1302_ce && pce) begin
            m_oe = 1'b0;
            if (rst_n) check("sclk_edges", m_cnt, 16);
            if (tx_count == 0) first_cmd = cmd;
            last_cmd = cmd;
            tx_count++;
            if (!cmd[0] && m_cnt == 16) begin
                commit_cnt++;
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: got %0h%0h", cmd, dat);
                end else begin
                    check("commit", {cmd, dat}, wr_q.pop_front());
                end
                if (cmd == 8'h8E) wp = dat[7];
                else if (!wp) regs[cmd[3:1]] = dat;
            end
        end
        pce = ds1302_ce;
        psc = ds1302_sclk;
    end

    // Snapshot monitor
    always @(negedge clk) begin
        snap_t e;
        if (rst_n && bus.read_valid) begin
            if (snap_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read_valid: sec %0h", bus.read_second);
            end else begin
                e = snap_q.pop_front();
                check("rd_sec",   bus.read_second, e[0]);
                check("rd_min",   bus.read_minute, e[1]);
                check("rd_hour",  bus.read_hour,   e[2]);
                check("rd_date",  bus.read_date,   e[3]);
                check("rd_month", bus.read_month,  e[4]);
                check("rd_week",  bus.read_week,   e[5]);
                check("rd_year",  bus.read_year,   e[6]);
            end
        end
    end

    int  low_run = 0;
    logic seen_tx = 1'b0;

    // CE low time between transactions
    always @(negedge clk) begin
        if (!ds1302_ce) begin
            low_run++;
        end else begin
            if (seen_tx && low_run > 0 && rst_n)
                check("ce_gap_ge8", low_run >= 8, 1);
            seen_tx = 1'b1;
            low_run = 0;
        end
    end

    task automatic set_wr(input logic [7:0] s, mi, h, d, mo, w, y);
        bus.write_second = s;
        bus.write_minute = mi;
        bus.write_hour   = h;
        bus.write_date   = d;
        bus.write_month  = mo;
        bus.write_week   = w;
        bus.write_year   = y;
    endtask

    task automatic push_wr(input logic [7:0] s, mi, h, d, mo, w, y);
        wr_q.push_back(16'h8E00);
        wr_q.push_back({8'h80, s & 8'h7F});
        wr_q.push_back({8'h82, mi});
        wr_q.push_back({8'h84, h & 8'h7F});
        wr_q.push_back({8'h86, d});
        wr_q.push_back({8'h88, mo});
        wr_q.push_back({8'h8A, w});
        wr_q.push_back({8'h8C, y});
        wr_q.push_back(16'h8E80);
    endtask

    task automatic wait_rv(input int max, input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.read_valid && cyc < max);
        if (!bus.read_valid) check(name, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, hi, idle, t0, n, c0;
        logic cmd_chk;
        snap_t s;
        regs[0] = 8'hC5; regs[1] = 8'h30; regs[2] = 8'h12; regs[3] = 8'h15;
        regs[4] = 8'h06; regs[5] = 8'h03; regs[6] = 8'h19; regs[7] = 8'h80;
        bus.write_req = 1'b0;
        set_wr(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_ce", ds1302_ce, 0);
        check("rst_sclk", ds1302_sclk, 0);
        check("rst_io_released", ds1302_io, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_read_valid", bus.read_valid, 0);
        check("rst_read_second", bus.read_second, 0);
        check("rst_read_year", bus.read_year, 0);

        s = {8'h19, 8'h03, 8'h06, 8'h15, 8'h12, 8'h30, 8'h45};
        snap_q.push_back(s);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (ds1302_ce) hi++;
        end
        check("ce_idle_poll", hi, 0);
        wait_rv(2000, "first_poll_timeout", cyc);
        n_cmp++;
        if (99 + cyc < 1078 || 99 + cyc > 1082) begin
            n_bad++;
            $display("FAIL poll_latency: got %0d want 1080", 99 + cyc);
        end
        check("first_cmd", first_cmd, 8'h81);
        check("idle_io_released", ds1302_io, 1);

        repeat (5) @(negedge clk);
        set_wr(8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
        push_wr(8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
        s = {8'h99, 8'h07, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58};
        snap_q.push_back(s);
        bus.write_req = 1'b1;
        @(negedge clk);
        bus.write_req = 1'b0;
        check("busy_write", bus.busy, 1);
        wait_rv(4000, "write_timeout", cyc);
        check("write_commits_left", wr_q.size(), 0);

        repeat (99) @(negedge clk);
        set_wr(8'h30, 8'h20, 8'h10, 8'h01, 8'h02, 8'h01, 8'h24);
        push_wr(8'h30, 8'h20, 8'h10, 8'h01, 8'h02, 8'h01, 8'h24);
        t0 = tx_count;
        bus.write_req = 1'b1;
        idle = 0;
        cmd_chk = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.write_req = 1'b0;
            if (i == 600) begin
                set_wr(8'h30, 8'h10, 8'h10, 8'h01, 8'h02, 8'h01, 8'h24);
                push_wr(8'h30, 8'h10, 8'h10, 8'h01, 8'h02, 8'h01, 8'h24);
                s = {8'h24, 8'h01, 8'h02, 8'h01, 8'h10, 8'h10, 8'h30};
                snap_q.push_back(s);
                bus.write_req = 1'b1;
            end
            if (bus.read_valid) break;
            if (!bus.busy) idle++;
            if (!cmd_chk && tx_count != t0) begin
                cmd_chk = 1'b1;
                check("collide_first_cmd", last_cmd, 8'h8E);
            end
        end
        check("collide_rv_seen", bus.read_valid, 1);
        check("collide_first_cmd_seen", cmd_chk, 1);
        check("collide_idle_cycles", idle, 0);
        check("collide_commits_left", wr_q.size(), 0);

        regs[2] = 8'hD2;
        regs[5] = 8'hF3;
        s = {8'h24, 8'h03, 8'h02, 8'h01, 8'h12, 8'h10, 8'h30};
        snap_q.push_back(s);
        wait_rv(3000, "mask_timeout", cyc);

        repeat (3) @(negedge clk);
        set_wr(8'h11, 8'h22, 8'h13, 8'h14, 8'h05, 8'h06, 8'h27);
        c0 = commit_cnt;
        bus.write_req = 1'b1;
        @(negedge clk);
        bus.write_req = 1'b0;
        n = 0;
        while (!(m_cnt == 6 && ds1302_sclk) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("slot5_reached", n < 2000, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ce", ds1302_ce, 0);
        check("abort_sclk", ds1302_sclk, 0);
        check("abort_io_released", ds1302_io, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_read_second", bus.read_second, 0);
        check("abort_read_hour", bus.read_hour, 0);
        repeat (20) @(negedge clk);
        check("abort_no_commit", commit_cnt, c0);
        check("snap_left", snap_q.size(), 0);
        check("commits_left", wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
